// File: rtl/conv_pkg.sv
// Shared types and constants for the conv transfer sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package conv_pkg;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    // Read channel indices
    localparam int CH_IFM = 0;
    localparam int CH_WGT = 1;

    // Default largest single request, in bytes (power of two)
    localparam int MAX_XFER_BYTES_DFLT = 4096;

endpackage

// File: rtl/xfer_chunker.sv
// Splits one stream's per-tile byte count into requests of at most MAX_XFER_BYTES.
// Latency: first req rises the cycle after kick; each next chunk rises two cycles after the previous done.
// Backpressure: req is held until done; done while req is low is ignored.
module xfer_chunker
    import conv_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int SIZE_W         = 32,
    parameter int MAX_XFER_BYTES = MAX_XFER_BYTES_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kick,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [SIZE_W-1:0] total_bytes,
    input  logic              done,
    output logic              req,
    output logic [ADDR_W-1:0] offset,
    output logic [SIZE_W-1:0] xfer_size,
    output logic              complete
);

    localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_XFER_BYTES);

    logic [ADDR_W-1:0] base_q;
    logic [SIZE_W-1:0] remaining;
    logic [SIZE_W-1:0] chunk_off;
    logic [SIZE_W-1:0] rem_after;
    logic              gap;

    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] n);
        return (n > MAX_SZ) ? MAX_SZ : n;
    endfunction

    // Bytes still owed once the chunk in flight completes
    assign rem_after = remaining - xfer_size;

    // Chunk walker: kick loads a new stream, done retires a chunk, gap issues the next one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            remaining <= '0;
            chunk_off <= '0;
            gap       <= 1'b0;
            req       <= 1'b0;
            offset    <= '0;
            xfer_size <= '0;
            complete  <= 1'b0;
        end else if (kick) begin
            base_q    <= base_addr;
            remaining <= total_bytes;
            chunk_off <= '0;
            gap       <= 1'b0;
            if (total_bytes == '0) begin
                req      <= 1'b0;
                complete <= 1'b1;
            end else begin
                req       <= 1'b1;
                offset    <= base_addr;
                xfer_size <= clamp_size(total_bytes);
                complete  <= 1'b0;
            end
        end else if (req && done) begin
            req       <= 1'b0;
            remaining <= rem_after;
            chunk_off <= chunk_off + xfer_size;
            if (rem_after == '0) begin
                complete <= 1'b1;
            end else begin
                gap <= 1'b1;
            end
        end else if (gap) begin
            // One idle cycle between chunks, then the next request
            gap       <= 1'b0;
            req       <= 1'b1;
            offset    <= base_q + ADDR_W'(chunk_off);
            xfer_size <= clamp_size(remaining);
        end
    end

endmodule

// File: rtl/conv_xfer_sequencer.sv
// Tile sequencer: chunked reads per tile, tile_start, wait tile_end, chunked OFM write, single end_conv. PERF_CNT_EN adds perf counters.
// Latency: busy the cycle after op_start, first reads one cycle later; end_conv one cycle after the last write completes (busy low then).
// Backpressure: every stream holds req until its done pulse; stall_in never gates requests, it only forms g_stall.
module conv_xfer_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_RD_CH      = 2,
    parameter int ADDR_W         = 64,
    parameter int SIZE_W         = 32,
    parameter int MAX_XFER_BYTES = MAX_XFER_BYTES_DFLT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          op_start,
    input  logic [SIZE_W-1:0]             cfg_tile_num,
    input  logic [NUM_RD_CH*ADDR_W-1:0]   cfg_rd_base,
    input  logic [NUM_RD_CH*SIZE_W-1:0]   cfg_rd_bytes,
    input  logic [NUM_RD_CH*SIZE_W-1:0]   cfg_rd_stride,
    input  logic [ADDR_W-1:0]             cfg_wr_base,
    input  logic [SIZE_W-1:0]             cfg_wr_bytes,
    input  logic [SIZE_W-1:0]             cfg_wr_stride,
    output logic [NUM_RD_CH-1:0]          rd_req,
    input  logic [NUM_RD_CH-1:0]          rd_done,
    output logic [NUM_RD_CH*ADDR_W-1:0]   rd_offset,
    output logic [NUM_RD_CH*SIZE_W-1:0]   rd_xfer_size,
    output logic                          wr_req,
    input  logic                          wr_done,
    output logic [ADDR_W-1:0]             wr_offset,
    output logic [SIZE_W-1:0]             wr_xfer_size,
    output logic                          tile_start,
    input  logic                          tile_end,
    input  logic [NUM_RD_CH:0]            stall_in,
    output logic                          g_stall,
    output logic                          busy,
    output logic                          end_conv
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                   perf_run_cycle,
    output logic [31:0]                   perf_stall_cycle,
    output logic [31:0]                   perf_xfer_cycle
`endif
);

    seq_state_t state, state_nxt;

    logic [SIZE_W-1:0]           cfg_tile_num_q;
    logic [NUM_RD_CH*ADDR_W-1:0] cfg_rd_base_q;
    logic [NUM_RD_CH*SIZE_W-1:0] cfg_rd_bytes_q;
    logic [NUM_RD_CH*SIZE_W-1:0] cfg_rd_stride_q;
    logic [ADDR_W-1:0]           cfg_wr_base_q;
    logic [SIZE_W-1:0]           cfg_wr_bytes_q;
    logic [SIZE_W-1:0]           cfg_wr_stride_q;
    logic [SIZE_W-1:0]           tile_idx;

    logic                 load_first;
    logic                 write_first;
    logic                 accept;
    logic                 tile_inc;
    logic                 tile_start_nxt;
    logic                 last_tile;
    logic                 rd_kick;
    logic                 wr_kick;
    logic [NUM_RD_CH-1:0] rd_complete;
    logic                 wr_complete;
    logic [ADDR_W-1:0]    wr_tile_addr;

    assign g_stall   = |stall_in;
    assign last_tile = (tile_idx == (cfg_tile_num_q - SIZE_W'(1)));
    // Chunkers are kicked in the first cycle of each phase; their complete flags
    // still describe the previous tile in that cycle, so they are ignored there.
    assign rd_kick   = (state == LOAD) && load_first && (cfg_tile_num_q != '0);
    assign wr_kick   = (state == WRITE) && write_first;

    // Next-state decode; tile_end is only honoured after the tile_start pulse cycle
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        tile_inc       = 1'b0;
        tile_start_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (op_start) begin
                    state_nxt = LOAD;
                    accept    = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_tile_num_q == '0) begin
                    state_nxt = DONE;
                end else if (!load_first && (&rd_complete)) begin
                    state_nxt      = COMPUTE;
                    tile_start_nxt = 1'b1;
                end
            end
            COMPUTE: begin
                if (tile_end && !tile_start) begin
                    if (cfg_wr_bytes_q != '0) begin
                        state_nxt = WRITE;
                    end else if (last_tile) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        tile_inc  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!write_first && wr_complete) begin
                    if (last_tile) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        tile_inc  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, registered outputs, config capture and tile counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            load_first      <= 1'b0;
            write_first     <= 1'b0;
            tile_start      <= 1'b0;
            busy            <= 1'b0;
            end_conv        <= 1'b0;
            tile_idx        <= '0;
            cfg_tile_num_q  <= '0;
            cfg_rd_base_q   <= '0;
            cfg_rd_bytes_q  <= '0;
            cfg_rd_stride_q <= '0;
            cfg_wr_base_q   <= '0;
            cfg_wr_bytes_q  <= '0;
            cfg_wr_stride_q <= '0;
        end else begin
            state       <= state_nxt;
            load_first  <= (state_nxt == LOAD) && (state != LOAD);
            write_first <= (state_nxt == WRITE) && (state != WRITE);
            tile_start  <= tile_start_nxt;
            busy        <= (state_nxt == LOAD) || (state_nxt == COMPUTE) || (state_nxt == WRITE);
            end_conv    <= (state_nxt == DONE);
            if (accept) begin
                tile_idx        <= '0;
                cfg_tile_num_q  <= cfg_tile_num;
                cfg_rd_base_q   <= cfg_rd_base;
                cfg_rd_bytes_q  <= cfg_rd_bytes;
                cfg_rd_stride_q <= cfg_rd_stride;
                cfg_wr_base_q   <= cfg_wr_base;
                cfg_wr_bytes_q  <= cfg_wr_bytes;
                cfg_wr_stride_q <= cfg_wr_stride;
            end else if (tile_inc) begin
                tile_idx <= tile_idx + SIZE_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_RD_CH; c++) begin : g_rd
        logic [ADDR_W-1:0] tile_addr;

        // Tile address wraps modulo 2^ADDR_W
        assign tile_addr = cfg_rd_base_q[c*ADDR_W +: ADDR_W]
                         + ADDR_W'(tile_idx) * ADDR_W'(cfg_rd_stride_q[c*SIZE_W +: SIZE_W]);

        xfer_chunker #(
            .ADDR_W         (ADDR_W),
            .SIZE_W         (SIZE_W),
            .MAX_XFER_BYTES (MAX_XFER_BYTES)
        ) u_rd_chunker (
            .clk         (clk),
            .rst_n       (rst_n),
            .kick        (rd_kick),
            .base_addr   (tile_addr),
            .total_bytes (cfg_rd_bytes_q[c*SIZE_W +: SIZE_W]),
            .done        (rd_done[c]),
            .req         (rd_req[c]),
            .offset      (rd_offset[c*ADDR_W +: ADDR_W]),
            .xfer_size   (rd_xfer_size[c*SIZE_W +: SIZE_W]),
            .complete    (rd_complete[c])
        );
    end

    assign wr_tile_addr = cfg_wr_base_q + ADDR_W'(tile_idx) * ADDR_W'(cfg_wr_stride_q);

    xfer_chunker #(
        .ADDR_W         (ADDR_W),
        .SIZE_W         (SIZE_W),
        .MAX_XFER_BYTES (MAX_XFER_BYTES)
    ) u_wr_chunker (
        .clk         (clk),
        .rst_n       (rst_n),
        .kick        (wr_kick),
        .base_addr   (wr_tile_addr),
        .total_bytes (cfg_wr_bytes_q),
        .done        (wr_done),
        .req         (wr_req),
        .offset      (wr_offset),
        .xfer_size   (wr_xfer_size),
        .complete    (wr_complete)
    );

`ifdef PERF_CNT_EN
    // Run / stall / transfer cycle counters, cleared by an accepted op_start, frozen when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_run_cycle   <= '0;
            perf_stall_cycle <= '0;
            perf_xfer_cycle  <= '0;
        end else if (accept) begin
            perf_run_cycle   <= '0;
            perf_stall_cycle <= '0;
            perf_xfer_cycle  <= '0;
        end else if (busy) begin
            perf_run_cycle <= perf_run_cycle + 32'd1;
            if (g_stall) begin
                perf_stall_cycle <= perf_stall_cycle + 32'd1;
            end
            if ((|rd_req) || wr_req) begin
                perf_xfer_cycle <= perf_xfer_cycle + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_xfer_sequencer.sv
// Directed bench for conv_xfer_sequencer: table of tile configs plus hand sequences for corner cases.
// Latency: memory responder answers each request 2 cycles after it rises; tile_end 3 cycles after tile_start.
// Backpressure: responder holds one outstanding request per stream; stall_in driven directly.
module tb_conv_xfer_sequencer;

    localparam logic [63:0] BASE0 = 64'h0000_1000;
    localparam logic [63:0] BASE1 = 64'h0010_0000;
    localparam logic [63:0] WBASE = 64'h0020_0000;
    localparam logic [31:0] STR0  = 32'h0000_0400;
    localparam logic [31:0] STR1  = 32'h0000_2000;
    localparam logic [31:0] WSTR  = 32'h0000_4000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_start;
    logic [31:0]  cfg_tile_num;
    logic [127:0] cfg_rd_base;
    logic [63:0]  cfg_rd_bytes;
    logic [63:0]  cfg_rd_stride;
    logic [63:0]  cfg_wr_base;
    logic [31:0]  cfg_wr_bytes;
    logic [31:0]  cfg_wr_stride;
    logic [1:0]   rd_req;
    logic [1:0]   rd_done;
    logic [127:0] rd_offset;
    logic [63:0]  rd_xfer_size;
    logic         wr_req;
    logic         wr_done;
    logic [63:0]  wr_offset;
    logic [31:0]  wr_xfer_size;
    logic         tile_start;
    logic         tile_end;
    logic [2:0]   stall_in;
    logic         g_stall;
    logic         busy;
    logic         end_conv;
`ifdef PERF_CNT_EN
    logic [31:0]  perf_run_cycle;
    logic [31:0]  perf_stall_cycle;
    logic [31:0]  perf_xfer_cycle;
`endif

    // Responder-driven and manually-driven input components
    logic [2:0] rsp_done;
    logic [1:0] man_rd_done;
    logic       man_wr_done;
    logic       te_auto;
    logic       te_man;
    logic       te_auto_en;

    assign rd_done  = rsp_done[1:0] | man_rd_done;
    assign wr_done  = rsp_done[2] | man_wr_done;
    assign tile_end = te_auto | te_man;

    always #5 clk = ~clk;

    conv_xfer_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_start      (op_start),
        .cfg_tile_num  (cfg_tile_num),
        .cfg_rd_base   (cfg_rd_base),
        .cfg_rd_bytes  (cfg_rd_bytes),
        .cfg_rd_stride (cfg_rd_stride),
        .cfg_wr_base   (cfg_wr_base),
        .cfg_wr_bytes  (cfg_wr_bytes),
        .cfg_wr_stride (cfg_wr_stride),
        .rd_req        (rd_req),
        .rd_done       (rd_done),
        .rd_offset     (rd_offset),
        .rd_xfer_size  (rd_xfer_size),
        .wr_req        (wr_req),
        .wr_done       (wr_done),
        .wr_offset     (wr_offset),
        .wr_xfer_size  (wr_xfer_size),
        .tile_start    (tile_start),
        .tile_end      (tile_end),
        .stall_in      (stall_in),
        .g_stall       (g_stall),
        .busy          (busy),
        .end_conv      (end_conv)
`ifdef PERF_CNT_EN
        ,
        .perf_run_cycle   (perf_run_cycle),
        .perf_stall_cycle (perf_stall_cycle),
        .perf_xfer_cycle  (perf_xfer_cycle)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Request log per stream (0 = IFM, 1 = WGT, 2 = OFM)
    logic [63:0] log_off [3][32];
    logic [31:0] log_sz  [3][32];
    int          log_n   [3];
    int          ts_cnt;
    int          ec_cnt;

    // Memory / accelerator responder, acting 1 time unit after each rising edge
    initial begin
        int cnt [3];
        bit pend [3];
        int te_cnt;
        logic r;
        logic [63:0] o;
        logic [31:0] z;
        for (int s = 0; s < 3; s++) begin
            cnt[s]  = 0;
            pend[s] = 1'b0;
            log_n[s] = 0;
        end
        te_cnt   = 0;
        rsp_done = '0;
        te_auto  = 1'b0;
        ts_cnt   = 0;
        ec_cnt   = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                if (s < 2) begin
                    r = rd_req[s];
                    o = rd_offset[s*64 +: 64];
                    z = rd_xfer_size[s*32 +: 32];
                end else begin
                    r = wr_req;
                    o = wr_offset;
                    z = wr_xfer_size;
                end
                rsp_done[s] = 1'b0;
                if (cnt[s] > 0) begin
                    cnt[s] = cnt[s] - 1;
                    if (cnt[s] == 0) rsp_done[s] = 1'b1;
                end
                if (r !== 1'b1) begin
                    pend[s] = 1'b0;
                end else if (!pend[s]) begin
                    pend[s] = 1'b1;
                    if (log_n[s] < 32) begin
                        log_off[s][log_n[s]] = o;
                        log_sz[s][log_n[s]]  = z;
                    end
                    log_n[s] = log_n[s] + 1;
                    cnt[s]   = 2;
                end
            end
            te_auto = 1'b0;
            if (te_cnt > 0) begin
                te_cnt = te_cnt - 1;
                if (te_cnt == 0) te_auto = 1'b1;
            end
            if (tile_start === 1'b1) begin
                ts_cnt = ts_cnt + 1;
                if (te_auto_en) te_cnt = 3;
            end
            if (end_conv === 1'b1) ec_cnt = ec_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        for (int s = 0; s < 3; s++) log_n[s] = 0;
        ts_cnt = 0;
        ec_cnt = 0;
    endtask

    // Model: every logged request of stream s against base/stride/chunking of bytes per tile
    task automatic check_stream(input int s, input logic [63:0] base, input logic [31:0] stride, input int bytes);
        int cpt;
        int n;
        int t;
        int j;
        logic [63:0] eo;
        logic [31:0] es;
        cpt = (bytes + 4095) / 4096;
        n   = (log_n[s] < 32) ? log_n[s] : 32;
        for (int k = 0; (k < n) && (cpt > 0); k++) begin
            t  = k / cpt;
            j  = k % cpt;
            eo = base + 64'(t) * 64'(stride) + 64'(j * 4096);
            es = (j == cpt - 1) ? 32'(bytes - j * 4096) : 32'd4096;
            check($sformatf("s%0d_off%0d", s, k), log_off[s][k], eo);
            check($sformatf("s%0d_sz%0d", s, k), 64'(log_sz[s][k]), 64'(es));
        end
    endtask

    task automatic set_cfg(input int tiles, input int b0, input int b1, input int wb);
        cfg_tile_num = 32'(tiles);
        cfg_rd_bytes = {32'(b1), 32'(b0)};
        cfg_wr_bytes = 32'(wb);
    endtask

    task automatic run_op(input int tiles, input int b0, input int b1, input int wb);
        int cyc;
        set_cfg(tiles, b0, b1, wb);
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        cyc = 0;
        while (end_conv !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("op_timeout", 64'(cyc < 3000), 64'd1);
        repeat (3) tick();
    endtask

    typedef struct {
        int tiles;
        int b0;
        int b1;
        int wb;
        int n0;
        int n1;
        int nw;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        int ec0;

        vecs[0] = '{1, 1000, 5000, 2048, 1, 2, 1};
        vecs[1] = '{3, 256, 4096, 8192, 3, 3, 6};
        vecs[2] = '{2, 64, 0, 128, 2, 0, 2};
        vecs[3] = '{2, 4097, 8, 0, 4, 2, 0};

        rst_n         = 1'b0;
        op_start      = 1'b0;
        cfg_rd_base   = {BASE1, BASE0};
        cfg_rd_stride = {STR1, STR0};
        cfg_wr_base   = WBASE;
        cfg_wr_stride = WSTR;
        set_cfg(1, 1000, 5000, 2048);
        man_rd_done   = '0;
        man_wr_done   = 1'b0;
        te_man        = 1'b0;
        te_auto_en    = 1'b1;
        stall_in      = '0;

        // Reset state
        repeat (3) tick();
        check("rst_rd_req", 64'(rd_req), 64'd0);
        check("rst_wr_req", 64'(wr_req), 64'd0);
        check("rst_rd_off", rd_offset[63:0], 64'd0);
        check("rst_flags", 64'({tile_start, busy, end_conv}), 64'd0);
        check("rst_g_stall", 64'(g_stall), 64'd0);
        stall_in = 3'b100;
        #1;
        check("g_stall_or", 64'(g_stall), 64'd1);
        stall_in = '0;
        rst_n = 1'b1;
        tick();

        // Single tile, detailed offsets and sizes
        clear_logs();
        run_op(1, 1000, 5000, 2048);
        check("st_n0", 64'(log_n[0]), 64'd1);
        check("st_sz0", 64'(log_sz[0][0]), 64'd1000);
        check("st_n1", 64'(log_n[1]), 64'd2);
        check("st_sz1a", 64'(log_sz[1][0]), 64'd4096);
        check("st_sz1b", 64'(log_sz[1][1]), 64'd904);
        check("st_off1a", log_off[1][0], 64'h0010_0000);
        check("st_off1b", log_off[1][1], 64'h0010_1000);
        check("st_wr_sz", 64'(log_sz[2][0]), 64'd2048);
        check("st_ts", 64'(ts_cnt), 64'd1);
        check("st_ec", 64'(ec_cnt), 64'd1);

        // Table of tile configurations
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            run_op(vecs[i].tiles, vecs[i].b0, vecs[i].b1, vecs[i].wb);
            check($sformatf("v%0d_n0", i), 64'(log_n[0]), 64'(vecs[i].n0));
            check($sformatf("v%0d_n1", i), 64'(log_n[1]), 64'(vecs[i].n1));
            check($sformatf("v%0d_nw", i), 64'(log_n[2]), 64'(vecs[i].nw));
            check($sformatf("v%0d_ts", i), 64'(ts_cnt), 64'(vecs[i].tiles));
            check($sformatf("v%0d_ec", i), 64'(ec_cnt), 64'd1);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
            check_stream(0, BASE0, STR0, vecs[i].b0);
            check_stream(1, BASE1, STR1, vecs[i].b1);
            check_stream(2, WBASE, WSTR, vecs[i].wb);
        end

        // Zero tiles: end_conv two cycles after op_start, no requests
        clear_logs();
        set_cfg(0, 1000, 5000, 2048);
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        check("z_busy_c1", 64'(busy), 64'd1);
        check("z_ec_c1", 64'(end_conv), 64'd0);
        tick();
        check("z_ec_c2", 64'(end_conv), 64'd1);
        tick();
        check("z_ec_c3", 64'(end_conv), 64'd0);
        check("z_busy_c3", 64'(busy), 64'd0);
        repeat (3) tick();
        check("z_no_req", 64'(log_n[0] + log_n[1] + log_n[2]), 64'd0);

        // Stray done / tile_end while idle
        man_rd_done = 2'b11;
        man_wr_done = 1'b1;
        te_man      = 1'b1;
        tick();
        man_rd_done = '0;
        man_wr_done = 1'b0;
        te_man      = 1'b0;
        tick();
        check("idle_stray", 64'({rd_req, wr_req, tile_start, busy, end_conv}), 64'd0);

        // tile_end during LOAD ignored; second op_start while busy ignored
        te_auto_en = 1'b0;
        clear_logs();
        set_cfg(1, 1000, 5000, 2048);
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        te_man   = 1'b1;
        tick();
        te_man = 1'b0;
        cyc = 0;
        while (ts_cnt == 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("sp_ts_wait", 64'(cyc < 200), 64'd1);
        cfg_tile_num = 32'd5;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (10) tick();
        check("sp_no_wr", 64'(wr_req), 64'd0);
        check("sp_busy", 64'(busy), 64'd1);
        te_man = 1'b1;
        tick();
        te_man = 1'b0;
        cyc = 0;
        while (end_conv !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("sp_ec_wait", 64'(cyc < 200), 64'd1);
        repeat (5) tick();
        check("sp_nw", 64'(log_n[2]), 64'd1);
        check("sp_ts", 64'(ts_cnt), 64'd1);
        check("sp_idle", 64'(busy), 64'd0);
        te_auto_en = 1'b1;

        // Reset in the middle of WRITE
        clear_logs();
        set_cfg(1, 1000, 5000, 2048);
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        cyc = 0;
        while (wr_req !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("rw_wr_wait", 64'(cyc < 300), 64'd1);
        ec0   = ec_cnt;
        rst_n = 1'b0;
        tick();
        check("rw_wr_req", 64'(wr_req), 64'd0);
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_ts", 64'(tile_start), 64'd0);
        check("rw_ec", 64'(end_conv), 64'd0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("rw_no_ec", 64'(ec_cnt), 64'(ec0));
        check("rw_quiet", 64'({rd_req, wr_req, busy}), 64'd0);
        clear_logs();
        run_op(1, 1000, 5000, 2048);
        check("rw_re_n1", 64'(log_n[1]), 64'd2);
        check("rw_re_nw", 64'(log_n[2]), 64'd1);
        check("rw_re_ec", 64'(ec_cnt), 64'd1);

`ifdef PERF_CNT_EN
        // Stall counter over exactly 10 busy cycles
        set_cfg(1, 1000, 5000, 2048);
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        stall_in = 3'b111;
        repeat (10) tick();
        stall_in = '0;
        cyc = 0;
        while (end_conv !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check("perf_stall", 64'(perf_stall_cycle), 64'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_xfer_sequencer.md
Name: conv_xfer_sequencer

Overview:
Tile-level transfer sequencer for the conv engine. It takes one op_start command and, for each tile, chunks the global-memory read requests for NUM_RD_CH input streams (IFM, WGT, optional bias). It then starts the accelerator, waits for tile completion, and chunks the OFM write-back. It replaces ad-hoc per-buffer request logic with strided multi-tile addressing and a single end_conv pulse.

Parameters:
NUM_RD_CH, 2, number of read streams (channel 0 = IFM, 1 = WGT, 2.. = extra)
ADDR_W, 64, global-memory address width
SIZE_W, 32, byte-count / tile-count width
MAX_XFER_BYTES, 4096, maximum bytes per read or write request; power of two

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
op_start  in  1  one-cycle command pulse
cfg_tile_num  in  SIZE_W  number of tiles
cfg_rd_base  in  NUM_RD_CH*ADDR_W  per-channel base address, packed, ch0 in LSBs
cfg_rd_bytes  in  NUM_RD_CH*SIZE_W  per-channel bytes per tile
cfg_rd_stride  in  NUM_RD_CH*SIZE_W  per-channel address stride per tile
cfg_wr_base  in  ADDR_W  OFM base
cfg_wr_bytes  in  SIZE_W  OFM bytes per tile
cfg_wr_stride  in  SIZE_W  OFM stride per tile
rd_req  out  NUM_RD_CH  per-channel request level
rd_done  in  NUM_RD_CH  per-channel completion pulse
rd_offset  out  NUM_RD_CH*ADDR_W  request address
rd_xfer_size  out  NUM_RD_CH*SIZE_W  request bytes
wr_req  out  1  write request level
wr_done  in  1  write completion pulse
wr_offset  out  ADDR_W  write address
wr_xfer_size  out  SIZE_W  write bytes
tile_start  out  1  one-cycle accelerator start pulse
tile_end  in  1  accelerator tile-complete pulse
stall_in  in  NUM_RD_CH+1  per-stream stall (read channels, then OFM)
g_stall  out  1  OR of stall_in, combinational
busy  out  1  high from the cycle after op_start until end_conv
end_conv  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs except g_stall are registered and reset to 0. State goes to IDLE. Config registers and counters clear.
- In IDLE, op_start latches all cfg_* inputs. The state moves to LOAD on the next cycle, and busy rises on that same cycle.
- op_start is ignored in any state other than IDLE.
- FSM states: IDLE, LOAD, COMPUTE, WRITE, DONE.
- Tile counter tile_idx runs from 0 to cfg_tile_num-1.
- If cfg_tile_num = 0, the FSM goes LOAD -> DONE with no requests.
- LOAD, per channel c, independently:
  - remaining = cfg_rd_bytes[c]; chunk offset starts at 0.
  - rd_offset = base + tile_idx*stride + chunk_off.
  - rd_xfer_size = min(remaining, MAX_XFER_BYTES).
  - rd_req[c] holds high until rd_done[c]. rd_req[c] drops on the cycle after done. The next chunk's request rises on the following cycle.
  - A channel with 0 bytes is complete immediately.
  - LOAD -> COMPUTE when all channels are complete. That transition cycle registers tile_start = 1 for one cycle.
- COMPUTE: wait for tile_end, then go to WRITE.
  - A tile_end arriving before tile_start has been issued is ignored.
- WRITE: same chunking on the wr_* ports.
  - When the write completes: if tile_idx = cfg_tile_num-1, go to DONE; otherwise tile_idx++ and go to LOAD.
  - cfg_wr_bytes = 0 skips WRITE.
- DONE: end_conv = 1 for one cycle, busy drops, and the state returns to IDLE.
- rd_done/wr_done arriving while the matching req is low is ignored. Simultaneous done pulses on several channels are all accepted in the same cycle.
- Address arithmetic:
  - Carried in ADDR_W bits; tile_idx*stride is zero-extended and wraps modulo 2^ADDR_W.
  - Sizes are SIZE_W bits.
  - The last chunk carries the remainder.
- Stall inputs do not gate requests; g_stall only feeds the datapath.
- Synchronous reset mid-operation aborts everything:
  - no end_conv is emitted;
  - outstanding done pulses arriving after reset are ignored.

Optional Feature:
PERF_CNT_EN.
- Defined: adds outputs perf_run_cycle, perf_stall_cycle and perf_xfer_cycle (each 32 bits).
  - They clear on accepted op_start.
  - While busy they increment on every cycle, on g_stall cycles, and on cycles with any req high, respectively.
  - They hold their values after end_conv.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Shared package conv_pkg holds:
  - the FSM state enum;
  - channel index constants CH_IFM = 0, CH_WGT = 1;
  - the MAX_XFER_BYTES default.
- One sub-module, xfer_chunker, contains the per-stream remaining/offset/req/done logic. It is instantiated NUM_RD_CH+1 times.

Test Plan:
- Single tile: NUM_RD_CH = 2, bytes = {1000, 5000}, MAX = 4096, tile_num = 1.
  - ch0 issues one request, size 1000.
  - ch1 issues 4096 then 904, offsets base and base+4096.
  - tile_start is issued once, then after tile_end a write of 2048; then end_conv.
- Multi-tile strides: tile_num = 3, ch0 stride 0x400, base 0x1000.
  - ch0 offsets are 0x1000, 0x1400, 0x1800.
  - Exactly 3 tile_start and 1 end_conv pulses.
- Zero cases:
  - tile_num = 0 gives end_conv 2 cycles after op_start, with no req.
  - A wgt channel with 0 bytes raises no rd_req[1].
- Spurious and busy inputs:
  - A stray rd_done while idle, and tile_end during LOAD, change nothing.
  - A second op_start while busy is ignored; busy stays 1.
- Reset mid-WRITE: wr_req, busy and tile_start go to 0 the next cycle, with no end_conv. A new op_start afterwards runs cleanly.
- PERF_CNT_EN: with stall_in held 1 for 10 busy cycles, perf_stall_cycle = 10.
